regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the pipelined core, replacing the fixed 2-read/1-write file. It has N read ports, two write ports (ALU writeback A, memory writeback B) and write-to-read bypass. A pending-write scoreboard lets ID stall on long-latency loads, and a registered debug port feeds the SoC. It sits between ID (reads, scoreboard set) and EX/MEM writeback.

## Interface
- XLEN, 32, register width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 2); register 0 hardwired to zero
- NRD, 2, number of read ports (1..4)
- AW, $clog2(NREGS), address width (derived, not overridden)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- rd_addr_i  in  NRD*AW  read addresses; port k at bits [k*AW +: AW]
- rd_data_o  out  NRD*XLEN  read data, combinational
- rd_busy_o  out  NRD  per-port "operand not yet available", combinational
- wa_en_i / wa_addr_i / wa_data_i  in  1 / AW / XLEN  write port A (ALU writeback)
- wb_en_i / wb_addr_i / wb_data_i  in  1 / AW / XLEN  write port B (load writeback)
- sb_set_i / sb_addr_i  in  1 / AW  mark a destination as pending (load issued)
- dbg_addr_i  in  AW  debug read address
- dbg_data_o  out  XLEN  debug read data, registered

## Operation
- Storage: NREGS x XLEN array plus NREGS-bit busy vector; entry 0 of both is constant 0.
- Write: port A writes when wa_en_i and wa_addr_i != 0; port B likewise.
- Both write ports target the same nonzero address in one cycle: port A's data is stored (A carries the younger instruction).
- Read port k, priority order:
  1. address 0 -> 0
  2. wa_en_i and wa_addr_i match -> wa_data_i
  3. wb_en_i and wb_addr_i match -> wb_data_i
  4. otherwise the array
- Scoreboard set: sb_set_i with sb_addr_i != 0 sets busy[sb_addr_i].
- Scoreboard clear: wb_en_i with wb_addr_i != 0 clears busy[wb_addr_i]. Port A never touches busy.
- Set and clear to the same address in one cycle: set wins (a new load supersedes the old one).
- rd_busy_o[k] = busy[addr_k] & ~(wb_en_i & wb_addr_i == addr_k). A same-cycle B writeback is bypassed, so it is not busy. Address 0 is never busy.
- Debug: dbg_data_o <= array[dbg_addr_i]. No bypass; shows the committed state as of the previous edge.

## Timing
- Reset, asserted on a clock edge:
  - every register, including the top index, cleared to 0
  - busy vector cleared
  - dbg_data_o = 0
- While rst is high: writes and sb_set_i are ignored; rd_data_o still follows the array/bypass mux (array is 0 after the first reset edge).
- Read latency 0 (combinational, including bypass). Write visible in the array from the edge after wX_en_i.
- Busy latency: sb_set_i at edge N makes rd_busy_o high from cycle N+1. A port B write at cycle M drops rd_busy_o combinationally in cycle M and busy is clear from M+1.
- Debug latency: 1 cycle.
- Reset mid-operation drops all pending busy bits; the pipeline flush is the owner's responsibility.

## Structure
- Shared package core_pkg holds XLEN, NREGS defaults and the reg_addr_t typedef.
- Sub-module regfile_scoreboard (NREGS, AW) owns the busy vector, set/clear priority and reset, and exposes the busy vector.
- regfile_mp contains the array, the write-priority logic, NRD instances of the bypass mux via a generate loop, and the debug register.

## Test plan
- Reset then read all addresses on all ports -> every rd_data_o = 0, rd_busy_o = 0, dbg_data_o = 0 including address NREGS-1.
- wa write x5=0xDEADBEEF while port 0 reads x5 -> same-cycle rd_data_o[0]=0xDEADBEEF; next cycle array value 0xDEADBEEF; dbg_addr=5 gives 0xDEADBEEF one cycle later.
- Same cycle wa x7=0x11, wb x7=0x22 -> read returns 0x11 that cycle and after; write to x0=0xFFFF -> x0 reads 0, busy[0] stays 0.
- sb_set x9, then 3 idle cycles -> rd_busy_o high for port reading x9; wb x9=0x1234 -> busy low same cycle, data 0x1234, stays clear.
- sb_set x9 and wb x9=0xAA same cycle -> data 0xAA stored, busy[9]=1 next cycle.
- NRD=4, NREGS=16 build: all four ports read distinct registers written earlier -> correct independent data; assert rst mid-run -> all registers and busy cleared next edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: default register-file geometry and address type.
package core_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set when a load
// issues and cleared when its writeback arrives on port B.
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_i,
  input  logic [AW-1:0]    set_addr_i,
  input  logic             clr_i,
  input  logic [AW-1:0]    clr_addr_i,
  output logic [NREGS-1:0] busy_o
);

  logic [NREGS-1:0] r_busy;

  // Clear first, then set, so a same-cycle set on the same register wins
  // (the newer load supersedes the one completing). Bit 0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      if (clr_i && (clr_addr_i != '0)) r_busy[clr_addr_i] <= 1'b0;
      if (set_i && (set_addr_i != '0)) r_busy[set_addr_i] <= 1'b1;
    end
  end

  assign busy_o = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational read ports with
// write-to-read bypass, two write ports (A = ALU, B = load), a load
// scoreboard and a registered debug read port.
module regfile_mp
  import core_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NRD*$clog2(NREGS)-1:0] rd_addr_i,
  output logic [NRD*XLEN-1:0]       rd_data_o,
  output logic [NRD-1:0]            rd_busy_o,
  input  logic                      wa_en_i,
  input  logic [$clog2(NREGS)-1:0]  wa_addr_i,
  input  logic [XLEN-1:0]           wa_data_i,
  input  logic                      wb_en_i,
  input  logic [$clog2(NREGS)-1:0]  wb_addr_i,
  input  logic [XLEN-1:0]           wb_data_i,
  input  logic                      sb_set_i,
  input  logic [$clog2(NREGS)-1:0]  sb_addr_i,
  input  logic [$clog2(NREGS)-1:0]  dbg_addr_i,
  output logic [XLEN-1:0]           dbg_data_o
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  r_mem [NREGS];
  logic [XLEN-1:0]  r_dbg;
  logic [NREGS-1:0] w_busy;
  logic             w_wa_we;
  logic             w_wb_we;

  assign w_wa_we = wa_en_i && (wa_addr_i != '0);
  assign w_wb_we = wb_en_i && (wb_addr_i != '0);

  // Array update: B is written first so that A (the younger instruction)
  // overwrites it when both target the same register. Entry 0 stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else begin
      r_mem[0] <= '0;
      if (w_wb_we) r_mem[wb_addr_i] <= wb_data_i;
      if (w_wa_we) r_mem[wa_addr_i] <= wa_data_i;
    end
  end

  // Debug port shows committed state only; no bypass.
  always_ff @(posedge clk) begin
    if (rst) r_dbg <= '0;
    else     r_dbg <= r_mem[dbg_addr_i];
  end

  assign dbg_data_o = r_dbg;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_i      (sb_set_i),
    .set_addr_i (sb_addr_i),
    .clr_i      (wb_en_i),
    .clr_addr_i (wb_addr_i),
    .busy_o     (w_busy)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;

    assign w_addr = rd_addr_i[k*AW +: AW];

    // Read mux: x0, then port A bypass, then port B bypass, then array.
    always_comb begin
      w_data = r_mem[w_addr];
      if (w_addr == '0)                          w_data = '0;
      else if (wa_en_i && (wa_addr_i == w_addr)) w_data = wa_data_i;
      else if (wb_en_i && (wb_addr_i == w_addr)) w_data = wb_data_i;
    end

    assign rd_data_o[k*XLEN +: XLEN] = w_data;

    // A same-cycle load writeback is bypassed, so the operand is available.
    assign rd_busy_o[k] = w_busy[w_addr] && (w_addr != '0) &&
                          !(wb_en_i && (wb_addr_i == w_addr));
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed, table-driven bench for regfile_mp in a 4-read-port, 16-register build.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 16;
  localparam int NRD   = 4;
  localparam int AW    = 4;

  logic                 clk;
  logic                 rst;
  logic [NRD*AW-1:0]    rd_addr_i;
  logic [NRD*XLEN-1:0]  rd_data_o;
  logic [NRD-1:0]       rd_busy_o;
  logic                 wa_en_i, wb_en_i, sb_set_i;
  logic [AW-1:0]        wa_addr_i, wb_addr_i, sb_addr_i, dbg_addr_i;
  logic [XLEN-1:0]      wa_data_i, wb_data_i, dbg_data_o;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .rd_busy_o  (rd_busy_o),
    .wa_en_i    (wa_en_i),
    .wa_addr_i  (wa_addr_i),
    .wa_data_i  (wa_data_i),
    .wb_en_i    (wb_en_i),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .sb_set_i   (sb_set_i),
    .sb_addr_i  (sb_addr_i),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wae;
    logic [3:0]  waa;
    logic [31:0] wad;
    logic        wbe;
    logic [3:0]  wba;
    logic [31:0] wbd;
    logic        sbs;
    logic [3:0]  sba;
    logic [3:0]  ra [4];
    logic [3:0]  dba;
    logic [31:0] ed [4];
    logic [3:0]  eb;
    logic [31:0] edbg;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  int n_vec  = 0;
  int n_fail = 0;

  function automatic vec_t mk(
    input logic rs, input logic wae, input logic [3:0] waa, input logic [31:0] wad,
    input logic wbe, input logic [3:0] wba, input logic [31:0] wbd,
    input logic sbs, input logic [3:0] sba,
    input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] r3,
    input logic [3:0] dba,
    input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3,
    input logic [3:0] eb, input logic [31:0] edbg);
    vec_t v;
    v.rst = rs; v.wae = wae; v.waa = waa; v.wad = wad;
    v.wbe = wbe; v.wba = wba; v.wbd = wbd; v.sbs = sbs; v.sba = sba;
    v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2; v.ra[3] = r3;
    v.dba = dba;
    v.ed[0] = e0; v.ed[1] = e1; v.ed[2] = e2; v.ed[3] = e3;
    v.eb = eb; v.edbg = edbg;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    wa_en_i = 1'b0; wa_addr_i = '0; wa_data_i = '0;
    wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    sb_set_i = 1'b0; sb_addr_i = '0;
    rd_addr_i = '0; dbg_addr_i = '0;
  endtask

  initial begin
    //             rs wa waa wad           wb wba wbd          sb sba r0  r1  r2  r3  dba e0            e1            e2            e3            eb       edbg
    tbl[0]  = mk(1, 0, 0,  0,            0, 0,  0,           0, 0,  0,  5,  7,  15, 15, 0,            0,            0,            0,            4'b0000, 0);
    tbl[1]  = mk(0, 0, 0,  0,            0, 0,  0,           0, 0,  1,  2,  14, 15, 15, 0,            0,            0,            0,            4'b0000, 0);
    tbl[2]  = mk(0, 1, 5,  32'hDEADBEEF, 0, 0,  0,           0, 0,  5,  0,  0,  0,  5,  32'hDEADBEEF, 0,            0,            0,            4'b0000, 0);
    tbl[3]  = mk(0, 0, 0,  0,            0, 0,  0,           0, 0,  5,  5,  0,  0,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0,            0,            4'b0000, 0);
    tbl[4]  = mk(0, 0, 0,  0,            0, 0,  0,           0, 0,  0,  0,  0,  5,  0,  0,            0,            0,            32'hDEADBEEF, 4'b0000, 32'hDEADBEEF);
    tbl[5]  = mk(0, 1, 7,  32'h11,       1, 7,  32'h22,      0, 0,  7,  7,  5,  0,  0,  32'h11,       32'h11,       32'hDEADBEEF, 0,            4'b0000, 0);
    tbl[6]  = mk(0, 1, 0,  32'hFFFF,     1, 0,  32'hEEEE,    1, 0,  7,  0,  0,  0,  7,  32'h11,       0,            0,            0,            4'b0000, 0);
    tbl[7]  = mk(0, 0, 0,  0,            0, 0,  0,           0, 0,  0,  7,  0,  0,  0,  0,            32'h11,       0,            0,            4'b0000, 32'h11);
    tbl[8]  = mk(0, 0, 0,  0,            0, 0,  0,           1, 9,  9,  0,  0,  0,  0,  0,            0,            0,            0,            4'b0000, 0);
    tbl[9]  = mk(0, 0, 0,  0,            0, 0,  0,           0, 0,  9,  9,  0,  0,  0,  0,            0,            0,            0,            4'b0011, 0);
    tbl[10] = mk(0, 0, 0,  0,            0, 0,  0,           0, 0,  0,  0,  9,  0,  0,  0,            0,            0,            0,            4'b0100, 0);
    tbl[11] = mk(0, 0, 0,  0,            0, 0,  0,           0, 0,  0,  0,  0,  9,  0,  0,            0,            0,            0,            4'b1000, 0);
    tbl[12] = mk(0, 0, 0,  0,            1, 9,  32'h1234,    0, 0,  9,  9,  0,  0,  0,  32'h1234,     32'h1234,     0,            0,            4'b0000, 0);
    tbl[13] = mk(0, 0, 0,  0,            0, 0,  0,           0, 0,  9,  0,  0,  0,  9,  32'h1234,     0,            0,            0,            4'b0000, 0);
    tbl[14] = mk(0, 0, 0,  0,            1, 9,  32'hAA,      1, 9,  9,  0,  0,  0,  9,  32'hAA,       0,            0,            0,            4'b0000, 32'h1234);
    tbl[15] = mk(0, 0, 0,  0,            0, 0,  0,           0, 0,  9,  0,  0,  0,  9,  32'hAA,       0,            0,            0,            4'b0001, 32'h1234);
    tbl[16] = mk(0, 1, 1,  32'h101,      1, 2,  32'h202,     0, 0,  1,  2,  3,  4,  0,  32'h101,      32'h202,      0,            0,            4'b0000, 32'hAA);
    tbl[17] = mk(0, 1, 3,  32'h303,      1, 15, 32'hF0F,     0, 0,  3,  15, 1,  2,  15, 32'h303,      32'hF0F,      32'h101,      32'h202,      4'b0000, 0);
    tbl[18] = mk(0, 0, 0,  0,            0, 0,  0,           0, 0,  1,  2,  3,  15, 15, 32'h101,      32'h202,      32'h303,      32'hF0F,      4'b0000, 0);
    tbl[19] = mk(0, 0, 0,  0,            0, 0,  0,           0, 0,  9,  15, 5,  7,  0,  32'hAA,       32'hF0F,      32'hDEADBEEF, 32'h11,       4'b0001, 32'hF0F);
    tbl[20] = mk(1, 1, 4,  32'h444,      0, 0,  0,           1, 4,  4,  9,  15, 5,  15, 32'h444,      32'hAA,       32'hF0F,      32'hDEADBEEF, 4'b0010, 0);
    tbl[21] = mk(0, 0, 0,  0,            0, 0,  0,           0, 0,  4,  9,  15, 5,  15, 0,            0,            0,            0,            4'b0000, 0);
    tbl[22] = mk(0, 0, 0,  0,            0, 0,  0,           0, 0,  1,  2,  3,  7,  7,  0,            0,            0,            0,            4'b0000, 0);
    tbl[23] = mk(0, 0, 0,  0,            0, 0,  0,           1, 10, 10, 0,  0,  0,  0,  0,            0,            0,            0,            4'b0000, 0);
    tbl[24] = mk(0, 1, 10, 32'hAAA5,     0, 0,  0,           0, 0,  10, 0,  0,  0,  0,  32'hAAA5,     0,            0,            0,            4'b0001, 0);
    tbl[25] = mk(0, 0, 0,  0,            0, 0,  0,           0, 0,  0,  10, 0,  0,  0,  0,            32'hAAA5,     0,            0,            4'b0010, 0);

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst        = tbl[i].rst;
      wa_en_i    = tbl[i].wae; wa_addr_i = tbl[i].waa; wa_data_i = tbl[i].wad;
      wb_en_i    = tbl[i].wbe; wb_addr_i = tbl[i].wba; wb_data_i = tbl[i].wbd;
      sb_set_i   = tbl[i].sbs; sb_addr_i = tbl[i].sba;
      rd_addr_i  = {tbl[i].ra[3], tbl[i].ra[2], tbl[i].ra[1], tbl[i].ra[0]};
      dbg_addr_i = tbl[i].dba;
      #2;
      for (int k = 0; k < NRD; k++)
        check($sformatf("v%0d rd_data[%0d]", i, k), rd_data_o[k*XLEN +: XLEN], tbl[i].ed[k]);
      check($sformatf("v%0d rd_busy", i), {28'd0, rd_busy_o}, {28'd0, tbl[i].eb});
      check($sformatf("v%0d dbg_data", i), dbg_data_o, tbl[i].edbg);
    end

    // Fill every nonzero register through port A, then read each back
    // through the debug port, which lags its address by one edge.
    for (int i = 1; i < NREGS; i++) begin
      @(negedge clk);
      idle_inputs();
      wa_en_i = 1'b1; wa_addr_i = 4'(i); wa_data_i = 32'h01010101 * i;
    end
    @(negedge clk);
    idle_inputs();
    for (int i = 1; i < NREGS; i++) begin
      @(negedge clk);
      dbg_addr_i = 4'(i);
      @(negedge clk);
      #2;
      check($sformatf("dbg x%0d", i), dbg_data_o, 32'h01010101 * i);
    end

    // Port A writes never clear the pending load on x10.
    rd_addr_i = {4'd0, 4'd0, 4'd0, 4'd10};
    #1;
    check("busy x10 after port A writes", {31'd0, rd_busy_o[0]}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
